alu_rs: RTL
===========

// Module: alu_rs
// PURPOSE
//  Reservation station for the ALU functional unit: buffers dispatched ALU ops until operands are ready.
//  Captures operand data from CDB broadcasts, selects the oldest ready entry, and issues it.
//  Issue goes through an output register that drives next_execute of the combinational ALU stage.
//  Sits between dispatch/rename (upstream) and the ALU execute stage (downstream).
// PARAMETERS
//  DEPTH     8   number of station entries (power of 2 not required, >=2)
//  NUM_CDB   2   number of CDB broadcast ports snooped for wakeup
// PORTS
//  clk             in   1                 clock, all state on rising edge
//  rst             in   1                 asynchronous, active-high reset
//  flush           in   1                 mispredict/pipeline flush
//  dispatch_valid  in   1                 dispatch_entry is valid this cycle
//  dispatch_entry  in   alu_rs_entry_t    op + operand tags/ready flags/data
//  dispatch_ready  out  1                 at least one free entry
//  cdb             in   to_writeback_t[NUM_CDB]  result broadcasts (valid, regf_we, rd_rob_idx, rd_data)
//  issue_stall     in   1                 downstream cannot accept; hold next_execute
//  next_execute    out  reservation_station_t  registered issue to ALU
//  occupancy       out  $clog2(DEPTH+1)   number of valid entries
// BEHAVIOUR
//  Reset (async): all entry valids=0, age matrix cleared, next_execute='0, occupancy=0; dispatch_ready=1.
//  dispatch_ready = ~&entry_valid, from current state only; space freed by this cycle's issue is ignored.
//  Dispatch: if dispatch_valid & dispatch_ready & ~flush, write the lowest-index free entry.
//   - Mark it younger than every currently valid entry.
//   - Store rdy flags as given; ops not needing rs1/rs2 arrive with rdy=1.
//   - Same-cycle CDB snoop on the incoming entry: a matching tag is written ready with CDB data.
//  Wakeup: per entry, per operand with rdy=0 and each CDB port where
//   valid & regf_we & rd_rob_idx==tag: latch rd_data into rsX_data and set rdy=1.
//   If two ports match the same tag, the lower port index wins.
//  Eligibility: valid & rs1_rdy & rs2_rdy as registered state.
//   Wakeup-to-issue latency is 1 cycle: an entry woken at edge t is selectable in the cycle after t.
//  Select: among eligible entries, the oldest per the age matrix (older[i][j]=1 when i was dispatched before j).
//  Issue (edge), when ~issue_stall & ~flush:
//   - next_execute <= selected op with valid=1; selected entry freed same edge.
//   - If nothing is eligible, next_execute.valid <= 0.
//  issue_stall=1: next_execute holds its value, no entry freed. Dispatch and wakeup continue.
//  Dispatch-to-issue: an entry dispatched ready at edge t appears on next_execute after edge t+1.
//  Issue and dispatch in the same cycle are legal; the freed slot is reusable next cycle.
//  flush=1 (priority over all):
//   - All entries invalid, next_execute.valid <= 0 at the next edge, even under issue_stall.
//   - That cycle's dispatch is dropped.
//  occupancy: registered popcount, updated each edge with +dispatch -issue -flush.
//  Full: dispatch_valid while dispatch_ready=0 is ignored (no state change).
// STRUCTURE
//  Package rv32i_types gains:
//   - ROB_IDX_W
//   - alu_rs_entry_t { reservation_station_t op; logic [ROB_IDX_W-1:0] rs1_tag, rs2_tag; logic rs1_rdy, rs2_rdy; }
//  Sub-module rs_age_select #(DEPTH): age matrix storage, update on alloc/free, oldest-eligible one-hot grant.
//  Top: entry array, free-slot priority encoder, CDB wakeup compare, output register.
// TESTING
//  1 Reset mid-operation with 3 entries valid -> next_execute.valid=0, occupancy=0, dispatch_ready=1 immediately.
//  2 Dispatch add, rs1 ready 5, rs2 ready 7 at edge0 -> after edge1 next_execute.valid=1, rs1_data=5, rs2_data=7; after edge2 valid=0.
//  3 Dispatch, rs2_tag=3 not ready; cdb[1] {valid,regf_we,rob 3,0xDEAD} at edge2 -> issues after edge3, rs2_data=0xDEAD.
//  4 Dispatch A (waits tag 2), then B ready; wake A; hold issue_stall until both are eligible, then release
//     -> A issues before B (age order, not index).
//  5 8 dispatches with never-broadcast tags -> dispatch_ready=0, occupancy=8; 9th dispatch ignored.
//     Flush under issue_stall -> next_execute.valid=0, occupancy=0.
//  6 Dispatch whose rs1_tag=4 is broadcast on CDB in the same cycle -> entry stored ready with CDB data, issues after next edge.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station: ALU op encoding, issue payload,
// station entry and CDB broadcast.
package alu_rs_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ROB_IDX_W = 4;
   localparam int unsigned RD_W      = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef struct packed {
      logic                 valid;
      alu_op_t              alu_op;
      logic [RD_W-1:0]      rd;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [XLEN-1:0]      rs1_data;
      logic [XLEN-1:0]      rs2_data;
   } reservation_station_t;

   typedef struct packed {
      reservation_station_t op;
      logic [ROB_IDX_W-1:0] rs1_tag;
      logic [ROB_IDX_W-1:0] rs2_tag;
      logic                 rs1_rdy;
      logic                 rs2_rdy;
   } alu_rs_entry_t;

   typedef struct packed {
      logic                 valid;
      logic                 regf_we;
      logic [ROB_IDX_W-1:0] rd_rob_idx;
      logic [XLEN-1:0]      rd_data;
   } to_writeback_t;

endpackage

// File: rtl/alu_rs_age_select.sv
// Age matrix for the reservation station: tracks dispatch order between slots and
// grants the oldest eligible slot (one-hot, combinational).
module rs_age_select #(
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic [DEPTH-1:0] alloc_i,
   input  logic [DEPTH-1:0] free_i,
   input  logic [DEPTH-1:0] valid_i,
   input  logic [DEPTH-1:0] eligible_i,
   output logic [DEPTH-1:0] grant_c
);

   // older_q[i][j] = 1 when slot i was dispatched before slot j
   logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) older_q <= '0;
      else     older_q <= older_d;
   end

   // Freed slots drop out of the ordering; a new slot is younger than all survivors
   always_comb begin
      older_d = older_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (free_i[i]) begin
            older_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][i] = 1'b0;
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (alloc_i[k]) begin
            older_d[k] = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][k] = valid_i[j] & ~free_i[j];
         end
      end
      if (flush_i) older_d = '0;
   end

   always_comb begin
      grant_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant_c[i] = eligible_i[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && eligible_i[j] && older_q[j][i]) grant_c[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops, wakes operands from the CDB,
// and issues the oldest ready op through a registered next_execute.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned NUM_CDB = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              dispatch_valid,
   input  alu_rs_entry_t                     dispatch_entry,
   output logic                              dispatch_ready,
   input  to_writeback_t [NUM_CDB-1:0]       cdb,
   input  logic                              issue_stall,
   output reservation_station_t              next_execute,
   output logic [$clog2(DEPTH+1)-1:0]        occupancy
);

   localparam int unsigned OCC_W = $clog2(DEPTH+1);

   alu_rs_entry_t [DEPTH-1:0] entry_q, entry_d;
   logic [DEPTH-1:0]          valid_q, valid_d;
   reservation_station_t      next_execute_q, next_execute_d;
   logic [OCC_W-1:0]          occ_q, occ_d;

   logic [DEPTH-1:0]          alloc_oh;
   logic [DEPTH-1:0]          eligible;
   logic [DEPTH-1:0]          grant;
   logic [DEPTH-1:0]          free_oh;
   logic                      do_dispatch;
   logic                      do_issue;
   alu_rs_entry_t             incoming;
   reservation_station_t      sel_op;

   // Returns {rdy, data}; scanning high-to-low lets the lowest matching port win
   function automatic logic [XLEN:0] snoop(input logic [ROB_IDX_W-1:0] tag,
                                           input logic rdy,
                                           input logic [XLEN-1:0] data,
                                           input to_writeback_t [NUM_CDB-1:0] bus);
      logic [XLEN:0] res;
      res = {rdy, data};
      if (!rdy) begin
         for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (bus[p].valid && bus[p].regf_we && bus[p].rd_rob_idx == tag)
               res = {1'b1, bus[p].rd_data};
         end
      end
      return res;
   endfunction

   assign dispatch_ready = ~&valid_q;
   assign do_dispatch    = dispatch_valid & dispatch_ready & ~flush;

   always_comb begin
      alloc_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_oh = DEPTH'(1) << i;
      end
      if (!do_dispatch) alloc_oh = '0;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         eligible[i] = valid_q[i] & entry_q[i].rs1_rdy & entry_q[i].rs2_rdy;
   end

   assign do_issue = ~issue_stall & ~flush & (|eligible);
   assign free_oh  = grant & {DEPTH{do_issue}};

   rs_age_select #(.DEPTH(DEPTH)) u_age (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .alloc_i    (alloc_oh),
      .free_i     (free_oh),
      .valid_i    (valid_q),
      .eligible_i (eligible),
      .grant_c    (grant)
   );

   always_comb begin
      sel_op = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel_op = entry_q[i].op;
      end
   end

   // Entry array, wakeup, allocation, output register and occupancy next-state
   always_comb begin
      entry_d        = entry_q;
      valid_d        = valid_q & ~free_oh;
      next_execute_d = next_execute_q;
      occ_d          = occ_q + OCC_W'(do_dispatch) - OCC_W'(do_issue);

      incoming = dispatch_entry;
      {incoming.rs1_rdy, incoming.op.rs1_data} =
         snoop(dispatch_entry.rs1_tag, dispatch_entry.rs1_rdy, dispatch_entry.op.rs1_data, cdb);
      {incoming.rs2_rdy, incoming.op.rs2_data} =
         snoop(dispatch_entry.rs2_tag, dispatch_entry.rs2_rdy, dispatch_entry.op.rs2_data, cdb);

      for (int i = 0; i < DEPTH; i++) begin
         {entry_d[i].rs1_rdy, entry_d[i].op.rs1_data} =
            snoop(entry_q[i].rs1_tag, entry_q[i].rs1_rdy, entry_q[i].op.rs1_data, cdb);
         {entry_d[i].rs2_rdy, entry_d[i].op.rs2_data} =
            snoop(entry_q[i].rs2_tag, entry_q[i].rs2_rdy, entry_q[i].op.rs2_data, cdb);
         if (alloc_oh[i]) begin
            entry_d[i] = incoming;
            valid_d[i] = 1'b1;
         end
      end

      if (!issue_stall) begin
         if (do_issue) begin
            next_execute_d       = sel_op;
            next_execute_d.valid = 1'b1;
         end else begin
            next_execute_d = '0;
         end
      end

      if (flush) begin
         valid_d              = '0;
         next_execute_d.valid = 1'b0;
         occ_d                = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q        <= '0;
         valid_q        <= '0;
         next_execute_q <= '0;
         occ_q          <= '0;
      end else begin
         entry_q        <= entry_d;
         valid_q        <= valid_d;
         next_execute_q <= next_execute_d;
         occ_q          <= occ_d;
      end
   end

   assign next_execute = next_execute_q;
   assign occupancy    = occ_q;

endmodule
